// File: rtl/prog_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding,
// instruction opcodes and default widths.
package prog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [2:0] OP_BR      = 3'b111;
    localparam logic [2:0] OP_CMP     = 3'b101;
    localparam logic [8:0] INSTR_HALT = 9'b110_000000;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_PC_W  = 10;

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter.
// Ports:
//   Clk   - clock
//   Reset - synchronous active-high reset, clears the count
//   inc   - increment request (ignored once the count is all-ones)
//   clr   - synchronous clear, has priority over inc
//   count - current count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: control-side partner of the instruction fetch unit.
// Decodes branch / compare / halt instructions, keeps the branch condition
// flag, and runs an IDLE/RUN/DONE program FSM that holds or releases the PC.
// Ports:
//   Clk, Reset   - clock, synchronous active-high reset
//   Go           - single-cycle request to launch the next program
//   Instr        - instruction currently addressed by ProgCtr
//   ProgCtr      - current PC from the fetch unit
//   AluFlagIn    - combinational condition result from the ALU
//   Start        - PC hold request to the fetch unit
//   BranchEn     - current instruction is a branch while running
//   ALU_flag     - registered branch condition flag
//   Target       - signed branch offset, Instr[5:0]
//   Done         - program halted
//   HaltPC       - ProgCtr captured at the halt instruction
//   CycleCount   - RUN cycles of the current program (saturating)
//   BranchCount  - taken branches of the current program (saturating)
module prog_sequencer
    import prog_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PC_W  = DEF_PC_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic [8:0]       Instr,
    input  logic [PC_W-1:0]  ProgCtr,
    input  logic             AluFlagIn,
    output logic             Start,
    output logic             BranchEn,
    output logic             ALU_flag,
    output logic [5:0]       Target,
    output logic             Done,
    output logic [PC_W-1:0]  HaltPC,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] BranchCount
);

    seq_state_t      state_reg, state_next;
    logic            first_reg, first_next;
    logic            alu_flag_reg;
    logic [PC_W-1:0] halt_pc_reg;

    logic is_br, is_cmp, is_halt;
    logic running;
    logic relaunch;   // DONE -> RUN: wipe per-program state
    logic halting;    // RUN -> DONE on this edge
    logic taken;

    // Instruction decode
    assign is_br   = (Instr[8:6] == OP_BR);
    assign is_cmp  = (Instr[8:6] == OP_CMP);
    assign is_halt = (Instr == INSTR_HALT);

    assign running = (state_reg == RUN);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            first_reg <= first_next;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_next = state_reg;
        first_next = first_reg;
        Start      = 1'b1;
        Done       = 1'b0;
        relaunch   = 1'b0;
        halting    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Go) begin
                    state_next = RUN;
                    first_next = 1'b1;
                end
            end
            RUN: begin
                Start      = 1'b0;
                first_next = 1'b0;
                // The PC was held on the HALT word of the previous program,
                // so the first RUN cycle re-fetches it; ignore it there.
                if (is_halt && !first_reg) begin
                    state_next = DONE;
                    halting    = 1'b1;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Go) begin
                    state_next = RUN;
                    first_next = 1'b1;
                    relaunch   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Branch decision uses the flag as registered before this cycle
    assign BranchEn = is_br && running;
    assign taken    = BranchEn && alu_flag_reg;

    always_ff @(posedge Clk) begin
        if (Reset || relaunch) begin
            alu_flag_reg <= 1'b0;
        end else if (running && is_cmp) begin
            alu_flag_reg <= AluFlagIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            halt_pc_reg <= '0;
        end else if (halting) begin
            halt_pc_reg <= ProgCtr;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (running),
        .clr   (relaunch),
        .count (CycleCount)
    );

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (taken),
        .clr   (relaunch),
        .count (BranchCount)
    );

    assign ALU_flag = alu_flag_reg;
    assign Target   = Instr[5:0];
    assign HaltPC   = halt_pc_reg;

endmodule
